// File: rtl/f_pkg.sv
// Shared F-pipeline definitions: default sizes, element width helpers and the packer state type.
package f_pkg;

  localparam int J_DEFAULT = 14;
  localparam int A_DEFAULT = 2;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int awidth_f(input int a);
    return $clog2(a) + 1;
  endfunction

  function automatic int idxw_f(input int j);
    return $clog2(j);
  endfunction

endpackage

// File: rtl/vec_out_reg.sv
// Valid/ready output holding register; data stays stable until the consumer takes it.
module vec_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         m_tready,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  output logic         free
);

  logic [W-1:0] data_r;
  logic         valid_r;

  assign free     = !valid_r || m_tready;
  assign m_tdata  = data_r;
  assign m_tvalid = valid_r;

  // a load takes priority over a drain so back-to-back vectors keep valid high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r  <= '0;
      valid_r <= 1'b0;
    end else if (load) begin
      data_r  <= din;
      valid_r <= 1'b1;
    end else if (m_tready) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/vec_packer.sv
// Serial-to-parallel packer regathering F results into a J-element vector.
// Optional VEC_PACKER_TLAST_EN adds s_tlast/m_tlast/short_err for early-closed vectors.
module vec_packer
  import f_pkg::*;
#(
  parameter int J = J_DEFAULT,
  parameter int A = A_DEFAULT,
  localparam int AWIDTH = awidth_f(A),
  parameter int DATAWIDTH = AWIDTH,
  localparam int IDXW = idxw_f(J)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATAWIDTH-1:0]   s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [J*DATAWIDTH-1:0] m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
`ifdef VEC_PACKER_TLAST_EN
  input  logic                   s_tlast,
  output logic                   m_tlast,
  output logic                   short_err,
`endif
  output logic [IDXW-1:0]        fill_idx
);

  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(J - 1);
`ifdef VEC_PACKER_TLAST_EN
  localparam int OW = J * DATAWIDTH + 1;
`else
  localparam int OW = J * DATAWIDTH;
`endif

  state_t                 state_r, state_nxt_s;
  logic [IDXW-1:0]        idx_r, idx_nxt_s;
  logic [J*DATAWIDTH-1:0] fill_r, fill_nxt_s, wr_s, load_data_s;
  logic                   s_tready_r;
  logic                   accept_s, close_s, early_s, out_free_s;
  logic                   load_s, hold_set_s;
  logic [OW-1:0]          out_din_s, out_q_s;

  assign accept_s = s_tvalid && s_tready_r;
  assign close_s  = (idx_r == IDX_LAST) || early_s;
  assign s_tready = s_tready_r;
  assign fill_idx = idx_r;
  assign m_tdata  = out_q_s[J*DATAWIDTH-1:0];

  // next-state, slot write and output-load decision
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    fill_nxt_s  = fill_r;
    wr_s        = fill_r;
    load_s      = 1'b0;
    load_data_s = fill_r;
    hold_set_s  = 1'b0;
    for (int k = 0; k < J; k++) begin
      if (int'(idx_r) == k) begin
        wr_s[k*DATAWIDTH +: DATAWIDTH] = s_tdata;
      end else begin
        wr_s[k*DATAWIDTH +: DATAWIDTH] = fill_r[k*DATAWIDTH +: DATAWIDTH];
      end
    end
    case (state_r)
      FILL: begin
        if (accept_s) begin
          fill_nxt_s = wr_s;
          if (close_s) begin
            idx_nxt_s = '0;
            // fill is cleared on every hand-off so unwritten slots read as zero
            if (out_free_s) begin
              load_s      = 1'b1;
              load_data_s = wr_s;
              fill_nxt_s  = '0;
            end else begin
              state_nxt_s = HOLD;
              hold_set_s  = 1'b1;
            end
          end else begin
            idx_nxt_s = idx_r + IDX_ONE;
          end
        end else begin
          fill_nxt_s = fill_r;
        end
      end
      HOLD: begin
        if (out_free_s) begin
          load_s      = 1'b1;
          load_data_s = fill_r;
          fill_nxt_s  = '0;
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = FILL;
      end
    endcase
  end

  // state, index, fill register and registered s_tready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= FILL;
      idx_r      <= '0;
      fill_r     <= '0;
      s_tready_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      fill_r     <= fill_nxt_s;
      s_tready_r <= (state_nxt_s == FILL);
    end
  end

`ifdef VEC_PACKER_TLAST_EN
  logic fill_last_r, short_err_r, load_last_s;

  assign early_s   = s_tlast;
  assign m_tlast   = out_q_s[OW-1];
  assign short_err = short_err_r;
  assign out_din_s = {load_last_s, load_data_s};

  // last flag travelling with a held vector, and the short-vector pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_last_r <= 1'b0;
      short_err_r <= 1'b0;
    end else begin
      short_err_r <= accept_s && s_tlast && (idx_r != IDX_LAST);
      if (hold_set_s) begin
        fill_last_r <= s_tlast;
      end else if (load_s) begin
        fill_last_r <= 1'b0;
      end
    end
  end

  // a held vector carries its stored flag; a direct load takes the live one
  always_comb begin
    if (state_r == HOLD) begin
      load_last_s = fill_last_r;
    end else begin
      load_last_s = s_tlast;
    end
  end
`else
  assign early_s   = 1'b0;
  assign out_din_s = load_data_s;
`endif

  vec_out_reg #(
    .W (OW)
  ) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .din      (out_din_s),
    .m_tready (m_tready),
    .m_tdata  (out_q_s),
    .m_tvalid (m_tvalid),
    .free     (out_free_s)
  );

endmodule

// File: tb/tb_vec_packer.sv
// Directed self-checking bench for vec_packer: J=4 instance plus a J=14 back-pressure instance.
module tb_vec_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] s_tdata;
  logic       s_tvalid, s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tready;
  logic [1:0] fill_idx;

  logic [1:0]  s_tdata14;
  logic        s_tvalid14, s_tready14;
  logic [27:0] m_tdata14;
  logic        m_tvalid14, m_tready14;
  logic [3:0]  fill_idx14;

`ifdef VEC_PACKER_TLAST_EN
  logic s_tlast, m_tlast, short_err;
  logic s_tlast14, m_tlast14, short_err14;
`endif

  int checks = 0;
  int errors = 0;

  vec_packer #(.J(4), .A(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
`ifdef VEC_PACKER_TLAST_EN
    .s_tlast(s_tlast), .m_tlast(m_tlast), .short_err(short_err),
`endif
    .fill_idx(fill_idx)
  );

  vec_packer #(.J(14), .A(2)) u_dut14 (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata14), .s_tvalid(s_tvalid14), .s_tready(s_tready14),
    .m_tdata(m_tdata14), .m_tvalid(m_tvalid14), .m_tready(m_tready14),
`ifdef VEC_PACKER_TLAST_EN
    .s_tlast(s_tlast14), .m_tlast(m_tlast14), .short_err(short_err14),
`endif
    .fill_idx(fill_idx14)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] elem14(input int n);
    int x;
    x = (n * 7 + n / 14) % 4;
    return x[1:0];
  endfunction

  function automatic logic [27:0] vec14(input int v);
    logic [27:0] r;
    r = '0;
    for (int k = 0; k < 14; k++) r[k*2 +: 2] = elem14(v * 14 + k);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 2'd0; m_tready = 1'b0;
    s_tvalid14 = 1'b0; s_tdata14 = 2'd0; m_tready14 = 1'b0;
`ifdef VEC_PACKER_TLAST_EN
    s_tlast = 1'b0; s_tlast14 = 1'b0;
`endif
    step(); step();
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got %0b want 0", m_tvalid); end
    checks++; if (m_tdata !== 8'h00) begin errors++; $display("FAIL reset_m_tdata got %h want 00", m_tdata); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready got %0b want 0", s_tready); end
    checks++; if (fill_idx !== 2'd0) begin errors++; $display("FAIL reset_fill_idx got %0d want 0", fill_idx); end
    rst_n = 1'b1;
    step();
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL release_s_tready got %0b want 1", s_tready); end
  endtask

  task automatic test_single();
    m_tready = 1'b1; s_tvalid = 1'b1;
    s_tdata = 2'd1; step();
    s_tdata = 2'd2; step();
    checks++; if (fill_idx !== 2'd2) begin errors++; $display("FAIL single_fill_idx got %0d want 2", fill_idx); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b want 0", m_tvalid); end
    s_tdata = 2'd3; step();
    s_tdata = 2'd0; step();
    s_tvalid = 1'b0;
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", m_tvalid); end
    checks++; if (m_tdata !== 8'h39) begin errors++; $display("FAIL single_data got %h want 39", m_tdata); end
    step();
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_one_cycle got %0b want 0", m_tvalid); end
  endtask

  task automatic test_stream();
    logic [7:0] exp_v [3];
    logic       exp_valid;
    int         x;
    exp_v = '{8'hE4, 8'hB1, 8'h4E};
    m_tready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      x = (c % 4) ^ (c / 4);
      s_tvalid = (c < 12);
      s_tdata  = x[1:0];
      step();
      exp_valid = (c % 4 == 3) && (c < 12);
      if (c < 12) begin
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL stream_s_tready cycle %0d got %0b want 1", c, s_tready); end
      end
      checks++; if (m_tvalid !== exp_valid) begin errors++; $display("FAIL stream_valid cycle %0d got %0b want %0b", c, m_tvalid, exp_valid); end
      if (exp_valid) begin
        checks++; if (m_tdata !== exp_v[c/4]) begin errors++; $display("FAIL stream_data cycle %0d got %h want %h", c, m_tdata, exp_v[c/4]); end
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic test_back_pressure();
    logic [1:0] seq [8];
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd3, 2'd0, 2'd1};
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_tvalid = 1'b1; s_tdata = seq[i];
      step();
      if (i == 3) begin
        checks++; if (m_tdata !== 8'h39 || m_tvalid !== 1'b1) begin errors++; $display("FAIL bp_first got %h/%0b want 39/1", m_tdata, m_tvalid); end
      end
    end
    s_tvalid = 1'b0;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_s_tready_low got %0b want 0", s_tready); end
    repeat (3) step();
    checks++; if (m_tdata !== 8'h39 || m_tvalid !== 1'b1) begin errors++; $display("FAIL bp_held got %h/%0b want 39/1", m_tdata, m_tvalid); end
    m_tready = 1'b1;
    step();
    checks++; if (m_tdata !== 8'h4F || m_tvalid !== 1'b1) begin errors++; $display("FAIL bp_second got %h/%0b want 4f/1", m_tdata, m_tvalid); end
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL bp_s_tready_back got %0b want 1", s_tready); end
    step();
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL bp_drained got %0b want 0", m_tvalid); end
  endtask

  task automatic test_mid_reset();
    logic [1:0] seq [4];
    seq = '{2'd3, 2'd2, 2'd1, 2'd0};
    m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = 2'd2;
    step(); step();
    rst_n = 1'b0; s_tvalid = 1'b0;
    step();
    checks++; if (m_tvalid !== 1'b0 || fill_idx !== 2'd0) begin errors++; $display("FAIL mid_reset got valid %0b idx %0d want 0/0", m_tvalid, fill_idx); end
    rst_n = 1'b1;
    step();
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin errors++; $display("FAIL mid_release got valid %0b ready %0b want 0/1", m_tvalid, s_tready); end
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tdata = seq[i];
      step();
      if (i < 3) begin
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_partial_valid elem %0d got %0b want 0", i, m_tvalid); end
      end
    end
    s_tvalid = 1'b0;
    checks++; if (m_tdata !== 8'h1B || m_tvalid !== 1'b1) begin errors++; $display("FAIL mid_clean_vector got %h/%0b want 1b/1", m_tdata, m_tvalid); end
    step();
  endtask

  task automatic test_j14();
    int   n_sent = 0;
    int   nv = 0;
    int   c = 0;
    logic acc, hs;
    while (nv < 40 && c < 3000) begin
      s_tvalid14 = (c % 3 != 2) && (n_sent < 560);
      m_tready14 = (c % 5 < 3);
      s_tdata14  = elem14(n_sent);
      acc = s_tvalid14 && s_tready14;
      hs  = m_tvalid14 && m_tready14;
      if (hs) begin
        checks++; if (m_tdata14 !== vec14(nv)) begin errors++; $display("FAIL j14_vector %0d got %h want %h", nv, m_tdata14, vec14(nv)); end
        nv++;
      end
      step();
      if (acc) n_sent++;
      c++;
    end
    checks++; if (nv != 40) begin errors++; $display("FAIL j14_timeout got %0d vectors want 40", nv); end
    s_tvalid14 = 1'b0; m_tready14 = 1'b1;
    step();
    checks++; if (m_tvalid14 !== 1'b0) begin errors++; $display("FAIL j14_extra_vector got %0b want 0", m_tvalid14); end
  endtask

`ifdef VEC_PACKER_TLAST_EN
  task automatic test_tlast();
    m_tready = 1'b1; s_tvalid = 1'b1;
    s_tdata = 2'd3; s_tlast = 1'b0; step();
    s_tdata = 2'd1; s_tlast = 1'b1; step();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++; if (m_tdata !== 8'h07 || m_tvalid !== 1'b1) begin errors++; $display("FAIL tlast_short_data got %h/%0b want 07/1", m_tdata, m_tvalid); end
    checks++; if (m_tlast !== 1'b1 || short_err !== 1'b1) begin errors++; $display("FAIL tlast_short_flags got %0b/%0b want 1/1", m_tlast, short_err); end
    step();
    checks++; if (short_err !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL tlast_pulse got %0b/%0b want 0/0", short_err, m_tvalid); end
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tdata = 2'(i); s_tlast = (i == 3);
      step();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++; if (m_tdata !== 8'hE4 || m_tlast !== 1'b1 || short_err !== 1'b0) begin errors++; $display("FAIL tlast_full got %h/%0b/%0b want e4/1/0", m_tdata, m_tlast, short_err); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_back_pressure();
    test_mid_reset();
    test_j14();
`ifdef VEC_PACKER_TLAST_EN
    test_tlast();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
